// File: rtl/trivium_pkg.sv
// trivium_pkg: shared widths, tap positions, FSM encodings and the
// Trivium state initialiser for the UART stream-cipher block.
package trivium_pkg;

  localparam int STATE_W              = 288;
  localparam int WARMUP_DEFAULT       = 4 * STATE_W;
  localparam int CLKS_PER_BIT_DEFAULT = 10416;

  // Tap positions, 1-based as in the Trivium description
  localparam int T1_A   = 66;
  localparam int T1_B   = 93;
  localparam int T1_AND = 91;
  localparam int T1_FB  = 171;
  localparam int T2_A   = 162;
  localparam int T2_B   = 177;
  localparam int T2_AND = 175;
  localparam int T2_FB  = 264;
  localparam int T3_A   = 243;
  localparam int T3_B   = 288;
  localparam int T3_AND = 286;
  localparam int T3_FB  = 69;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    CORE_WARM,
    CORE_FILL,
    CORE_READY
  } core_state_e;

  // s1..s80 = key, s94..s173 = iv, s286..s288 = 1, rest 0
  function automatic logic [STATE_W:1] init_state(
    input logic [79:0] key,
    input logic [79:0] iv
  );
    logic [STATE_W:1] s;
    s = '0;
    s[80:1] = key;
    s[173:94] = iv;
    s[288:286] = 3'b111;
    return s;
  endfunction

endpackage

// File: rtl/trivium_core.sv
// trivium_core: Trivium keystream generator with warm-up and byte packing.
// Ports: clk, rst (async, active-high, reloads key/iv), ena (hold when 0),
//   next (consume ks_byte, start next byte), ks_byte, ks_ready.
module trivium_core
  import trivium_pkg::*;
#(
  parameter logic [79:0] KEY           = 80'h0,
  parameter logic [79:0] IV            = 80'h0,
  parameter int          WARMUP_CYCLES = WARMUP_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       next,
  output logic [7:0] ks_byte,
  output logic       ks_ready
);

  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  localparam logic [WW-1:0] WARM_END = WW'(WARMUP_CYCLES - 1);

  logic [STATE_W:1] s;
  logic [WW-1:0]    warm_cnt;
  logic [2:0]       bit_cnt;
  core_state_e      st;
  core_state_e      st_n;
  logic             step;
  logic             t1;
  logic             t2;
  logic             t3;
  logic             z;
  logic             t1n;
  logic             t2n;
  logic             t3n;

  always_comb begin
    t1  = s[T1_A] ^ s[T1_B];
    t2  = s[T2_A] ^ s[T2_B];
    t3  = s[T3_A] ^ s[T3_B];
    z   = t1 ^ t2 ^ t3;
    t1n = t1 ^ (s[T1_AND] & s[T1_AND+1]) ^ s[T1_FB];
    t2n = t2 ^ (s[T2_AND] & s[T2_AND+1]) ^ s[T2_FB];
    t3n = t3 ^ (s[T3_AND] & s[T3_AND+1]) ^ s[T3_FB];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= CORE_WARM;
    else if (ena) st <= st_n;
  end

  always_comb begin
    st_n = st;
    step = 1'b0;
    unique case (st)
      CORE_WARM: begin
        step = 1'b1;
        if (warm_cnt == WARM_END) st_n = CORE_FILL;
      end
      CORE_FILL: begin
        step = 1'b1;
        if (bit_cnt == 3'd7) st_n = CORE_READY;
      end
      CORE_READY: begin
        if (next) st_n = CORE_FILL;
      end
      default: st_n = CORE_WARM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s        <= init_state(KEY, IV);
      warm_cnt <= '0;
      bit_cnt  <= '0;
      ks_byte  <= '0;
    end else if (ena) begin
      // three registers shift by one, fed by the cross-coupled taps
      if (step) begin
        s <= {s[287:178], t2n, s[176:94], t1n, s[92:1], t3n};
      end
      if (st == CORE_WARM) warm_cnt <= warm_cnt + 1'b1;
      if (st == CORE_FILL) begin
        ks_byte[bit_cnt] <= z;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign ks_ready = (st == CORE_READY);

endmodule

// File: rtl/trivium_uart_cipher.sv
// trivium_uart_cipher: 8N1 UART in, byte XOR Trivium keystream, 8N1 out.
// Ports: clk, rst_n (async, ACTIVE-HIGH), ena (hold all state, line high),
//   serial_in (RX, idle high, LSB first), serial_out (TX, idle high).
module trivium_uart_cipher
  import trivium_pkg::*;
#(
  parameter int          CLKS_PER_BIT  = CLKS_PER_BIT_DEFAULT,
  parameter logic [79:0] KEY           = 80'h0,
  parameter logic [79:0] IV            = 80'h0,
  parameter int          WARMUP_CYCLES = WARMUP_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic serial_in,
  output logic serial_out
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  logic sync1;
  logic sync2;

  rx_state_e rx_st;
  rx_state_e rx_n;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_clr;
  logic          rx_sample;
  logic          rx_valid;

  tx_state_e tx_st;
  tx_state_e tx_n;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          tx_clr;
  logic          tx_shift_en;
  logic          tx_load;
  logic          tx_line;

  logic       pending;
  logic [7:0] pend_byte;
  logic [7:0] ks_byte;
  logic       ks_ready;

  trivium_core #(
    .KEY          (KEY),
    .IV           (IV),
    .WARMUP_CYCLES(WARMUP_CYCLES)
  ) u_core (
    .clk     (clk),
    .rst     (rst_n),
    .ena     (ena),
    .next    (tx_load),
    .ks_byte (ks_byte),
    .ks_ready(ks_ready)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) {sync2, sync1} <= 2'b11;
    else if (ena) {sync2, sync1} <= {sync1, serial_in};
  end

  // ---------------- RX ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) rx_st <= RX_IDLE;
    else if (ena) rx_st <= rx_n;
  end

  always_comb begin
    rx_n      = rx_st;
    rx_clr    = 1'b0;
    rx_sample = 1'b0;
    rx_valid  = 1'b0;
    unique case (rx_st)
      RX_IDLE: begin
        if (!sync2) begin
          rx_n   = RX_START;
          rx_clr = 1'b1;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_END) begin
          rx_clr = 1'b1;
          rx_n   = sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_END) begin
          rx_clr    = 1'b1;
          rx_sample = 1'b1;
          if (rx_idx == 3'd7) rx_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_END) begin
          rx_clr   = 1'b1;
          rx_valid = sync2;
          rx_n     = RX_IDLE;
        end
      end
      default: rx_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else if (ena) begin
      rx_cnt <= rx_clr ? '0 : rx_cnt + 1'b1;
      if (rx_st == RX_IDLE) rx_idx <= '0;
      if (rx_sample) begin
        rx_shift <= {sync2, rx_shift[7:1]};
        rx_idx   <= rx_idx + 1'b1;
      end
    end
  end

  // ------------- pending byte -------------
  // A fresh byte wins over a load in the same cycle; the load
  // has already taken the old value.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pending   <= 1'b0;
      pend_byte <= '0;
    end else if (ena) begin
      if (rx_valid) begin
        pending   <= 1'b1;
        pend_byte <= rx_shift;
      end else if (tx_load) begin
        pending <= 1'b0;
      end
    end
  end

  // ---------------- TX ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) tx_st <= TX_IDLE;
    else if (ena) tx_st <= tx_n;
  end

  always_comb begin
    tx_n        = tx_st;
    tx_clr      = 1'b0;
    tx_shift_en = 1'b0;
    tx_load     = pending && ks_ready && (tx_st == TX_IDLE);
    unique case (tx_st)
      TX_IDLE: begin
        if (tx_load) begin
          tx_n   = TX_START;
          tx_clr = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_END) begin
          tx_n   = TX_DATA;
          tx_clr = 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_END) begin
          tx_clr      = 1'b1;
          tx_shift_en = 1'b1;
          if (tx_idx == 3'd7) tx_n = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_END) begin
          tx_clr = 1'b1;
          tx_n   = TX_IDLE;
        end
      end
      default: tx_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else if (ena) begin
      tx_cnt <= tx_clr ? '0 : tx_cnt + 1'b1;
      if (tx_load) begin
        tx_shift <= pend_byte ^ ks_byte;
        tx_idx   <= '0;
      end else if (tx_shift_en) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_idx   <= tx_idx + 1'b1;
      end
    end
  end

  always_comb begin
    tx_line = 1'b1;
    unique case (tx_st)
      TX_START: tx_line = 1'b0;
      TX_DATA:  tx_line = tx_shift[0];
      default:  tx_line = 1'b1;
    endcase
  end

  assign serial_out = ena ? tx_line : 1'b1;

endmodule

// File: tb/tb_trivium_uart_cipher.sv
// tb_trivium_uart_cipher: directed UART frames against a bit-level
// Trivium keystream model and a frame decoder on serial_out.
module tb_trivium_uart_cipher;

  localparam int          CPB   = 16;
  localparam int          WARM  = 1152;
  localparam int          NKS   = 16;
  localparam logic [79:0] KEY_P = 80'h0;
  localparam logic [79:0] IV_P  = 80'h0;

  logic clk       = 1'b0;
  logic rst_n     = 1'b1;
  logic ena       = 1'b1;
  logic serial_in = 1'b1;
  logic serial_out;

  trivium_uart_cipher #(
    .CLKS_PER_BIT (CPB),
    .KEY          (KEY_P),
    .IV           (IV_P),
    .WARMUP_CYCLES(WARM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .serial_in (serial_in),
    .serial_out(serial_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] ks [NKS];
  int         ks_idx = 0;
  logic [7:0] exp_q [$];

  int         frames = 0;
  logic [7:0] last_frame = 8'h00;
  bit         mon_busy = 1'b0;
  int         mon_cyc = 0;
  logic [7:0] mon_data = 8'h00;
  logic [7:0] want;

  // Keystream straight from the Trivium definition on a 1-based bit array
  task automatic build_keystream();
    bit s [1:288];
    bit t1, t2, t3, z, a1, a2, a3;
    logic [79:0] kv;
    logic [79:0] iv;
    kv = KEY_P;
    iv = IV_P;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = kv[i-1];
      s[93 + i] = iv[i-1];
    end
    s[286] = 1'b1;
    s[287] = 1'b1;
    s[288] = 1'b1;
    for (int n = 0; n < WARM + 8 * NKS; n++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z  = t1 ^ t2 ^ t3;
      a1 = t1 ^ (s[91] & s[92]) ^ s[171];
      a2 = t2 ^ (s[175] & s[176]) ^ s[264];
      a3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 288; i > 1; i--) s[i] = s[i-1];
      s[1]   = a3;
      s[94]  = a1;
      s[178] = a2;
      if (n >= WARM) ks[(n - WARM) / 8][(n - WARM) % 8] = z;
    end
  endtask

  // Frame decoder and per-cycle line checks
  always @(negedge clk) begin
    if (rst_n || !ena) begin
      checks++;
      if (serial_out !== 1'b1) begin
        errors++;
        $display("FAIL forced_high got %b want 1", serial_out);
      end
      if (rst_n) mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (exp_q.size() == 0) begin
        checks++;
        if (serial_out !== 1'b1) begin
          errors++;
          $display("FAIL idle_line got %b want 1", serial_out);
        end
      end
      if (serial_out === 1'b0) begin
        mon_busy = 1'b1;
        mon_cyc  = 0;
      end
    end else begin
      mon_cyc++;
      if (mon_cyc == CPB / 2) begin
        if (serial_out !== 1'b0) begin
          checks++;
          errors++;
          $display("FAIL start_bit got %b want 0", serial_out);
          mon_busy = 1'b0;
        end
      end else if (mon_cyc < CPB / 2 + 9 * CPB) begin
        if ((mon_cyc - CPB / 2) % CPB == 0)
          mon_data[(mon_cyc - CPB / 2) / CPB - 1] = serial_out;
      end else if (mon_cyc == CPB / 2 + 9 * CPB) begin
        mon_busy = 1'b0;
        frames++;
        last_frame = mon_data;
        checks++;
        if (serial_out !== 1'b1) begin
          errors++;
          $display("FAIL stop_bit got %b want 1", serial_out);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame got %02h want none", mon_data);
        end else begin
          want = exp_q.pop_front();
          if (mon_data !== want) begin
            errors++;
            $display("FAIL frame %0d got %02h want %02h", frames, mon_data, want);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_raw(input logic [7:0] d, input logic stop_ok);
    serial_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      tick(CPB);
    end
    if (stop_ok) begin
      serial_in = 1'b1;
      tick(CPB);
    end else begin
      serial_in = 1'b0;
      tick(CPB / 2 + 4);
      serial_in = 1'b1;
      tick(2 * CPB);
    end
  endtask

  task automatic send(input logic [7:0] d);
    exp_q.push_back(d ^ ks[ks_idx]);
    ks_idx++;
    send_raw(d, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || mon_busy) begin
      errors++;
      $display("FAIL wait_idle got %0d outstanding want 0", exp_q.size());
    end
    tick(CPB);
  endtask

  task automatic reset_dut();
    rst_n = 1'b1;
    exp_q.delete();
    ks_idx = 0;
    tick(3);
    rst_n = 1'b0;
    tick(WARM + 40);
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    logic [7:0] c;
    logic [7:0] data [10];
    data = '{8'hA5, 8'h3C, 8'h7F, 8'hC1, 8'h99,
             8'h42, 8'hE7, 8'hB8, 8'h5D, 8'hF0};
    build_keystream();

    // 1: reset, idle, keystream ready exactly after warm-up + 8
    tick(3);
    check_bit("reset_line", serial_out, 1'b1);
    rst_n = 1'b0;
    tick(WARM + 7);
    check_bit("ks_not_ready", dut.u_core.ks_ready, 1'b0);
    tick(1);
    check_bit("ks_ready", dut.u_core.ks_ready, 1'b1);
    tick(20);
    check_int("no_frames_idle", frames, 0);

    // 2: two zero bytes give K0, K1
    send(8'h00);
    send(8'h00);
    wait_idle(1000);

    // 3: ten back-to-back bytes
    for (int i = 0; i < 10; i++) send(data[i]);
    wait_idle(2000);
    check_int("frames_after_burst", frames, 12);

    // 4: involution
    reset_dut();
    send(8'hA5);
    wait_idle(1000);
    c = last_frame;
    reset_dut();
    exp_q.push_back(8'hA5);
    send_raw(c, 1'b1);
    wait_idle(1000);
    check_int("involution", int'(last_frame), 8'hA5);

    // 5: glitch rejected, framing error discarded
    reset_dut();
    f0 = frames;
    serial_in = 1'b0;
    tick(5);
    serial_in = 1'b1;
    tick(3 * CPB);
    check_int("glitch_no_frame", frames, f0);
    check_bit("glitch_ks_kept", dut.u_core.ks_ready, 1'b1);
    send(8'h00);
    wait_idle(1000);
    reset_dut();
    f0 = frames;
    send_raw(8'h5A, 1'b0);
    tick(12 * CPB);
    check_int("bad_stop_no_frame", frames, f0);
    send(8'h00);
    wait_idle(1000);

    // 6: reset mid TX frame, then ena pause mid frame
    reset_dut();
    send(8'h00);
    tick(40);
    check_int("mid_frame_busy", int'(mon_busy), 1);
    rst_n = 1'b1;
    #1;
    check_bit("async_reset_line", serial_out, 1'b1);
    exp_q.delete();
    ks_idx = 0;
    tick(3);
    rst_n = 1'b0;
    tick(WARM + 40);
    send(8'h00);
    wait_idle(1000);
    f0 = frames;
    send(8'h3C);
    tick(40);
    ena = 1'b0;
    tick(5000);
    check_int("pause_no_frame", frames, f0);
    ena = 1'b1;
    wait_idle(1000);
    check_int("pause_frame_done", frames, f0 + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
